// File: rtl/al4s3b_wb_pkg.sv
// Shared definitions for the Wishbone slot decoder.
// State encoding, bus data width and default read value.
package al4s3b_wb_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] DEF_READ_VALUE = 32'hBAD_FAB_AC;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FORCE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_FORCE  = ST_FORCE,
    S_DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/al4s3b_wb_timeout.sv
// Bus watchdog: transfer cycle counter plus the
// saturating forced-ACK counter and last fault address.
module al4s3b_wb_timeout #(
  parameter int APERWIDTH      = 17,
  parameter int TIMEOUT_CYCLES = 7,
  parameter int CNTR_WIDTH     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 inc,
  input  logic                 fire,
  input  logic [APERWIDTH-1:0] adr,
  output logic                 expired,
  output logic                 timeout,
  output logic [15:0]          err_cnt,
  output logic [APERWIDTH-1:0] err_adr
);

  logic [CNTR_WIDTH-1:0] cnt;

  // Cycle counter: starts at 1 on transfer start, counts while active
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNTR_WIDTH'(1);
    end else if (inc) begin
      cnt <= cnt + CNTR_WIDTH'(1);
    end
  end

  assign expired = (cnt == CNTR_WIDTH'(TIMEOUT_CYCLES));
  assign timeout = fire;

  // Error log: count saturates at all-ones, address of last forced ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      err_adr <= '0;
    end else if (fire) begin
      err_adr <= adr;
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/al4s3b_wb_slot_decoder.sv
// Wishbone aperture decoder/mux from the AHB bridge to N slaves,
// with a watchdog that forces an ACK on unmapped or silent slots.
module al4s3b_wb_slot_decoder
  import al4s3b_wb_pkg::*;
#(
  parameter int          NUM_SLOTS          = 4,
  parameter int          APERWIDTH          = 17,
  parameter int          APERSIZE           = 10,
  parameter int          SLOT_OFFSET        = 0,
  parameter logic [15:0] BYTE0_WR_MASK      = 16'h0000,
  parameter int          TIMEOUT_CYCLES     = 7,
  parameter int          CNTR_WIDTH         = 3,
  parameter logic [31:0] DEFAULT_READ_VALUE = DEF_READ_VALUE
) (
  input  logic                        WBs_CLK_i,
  input  logic                        WBs_RST_i,
  input  logic [APERWIDTH-1:0]        WBs_ADR_i,
  input  logic                        WBs_CYC_i,
  input  logic [3:0]                  WBs_BYTE_STB_i,
  input  logic                        WBs_WE_i,
  input  logic                        WBs_RD_i,
  input  logic                        WBs_STB_i,
  output logic [DATA_W-1:0]           WBs_DAT_o,
  output logic                        WBs_ACK_o,
  output logic [NUM_SLOTS-1:0]        Slv_CYC_o,
  input  logic [DATA_W*NUM_SLOTS-1:0] Slv_DAT_i,
  input  logic [NUM_SLOTS-1:0]        Slv_ACK_i,
  output logic                        Timeout_o,
  output logic [15:0]                 Err_Cnt_o,
  output logic [APERWIDTH-1:0]        Err_Adr_o
);

  localparam int SLOT_W = APERWIDTH - APERSIZE - 2;

  state_t state, state_nx;

  logic [SLOT_W-1:0]    slot;
  int                   slot_idx;
  logic [NUM_SLOTS-1:0] hit;
  logic [DATA_W-1:0]    sel_dat;
  logic                 sel_ack;
  logic                 cyc_ok;
  logic                 ack;
  logic [DATA_W-1:0]    dat;
  logic                 load;
  logic                 inc;
  logic                 fire;
  logic                 expired;
  logic                 timeout;
  logic                 unused_bits;

  assign slot     = WBs_ADR_i[APERWIDTH-1:APERSIZE+2];
  assign slot_idx = 32'(slot);
  assign cyc_ok   = (state == S_IDLE) || (state == S_ACTIVE);

  assign unused_bits = ^{WBs_BYTE_STB_i[3:1],
                         WBs_ADR_i[APERSIZE+1:0]};

  // Slot decode and read-data/ACK select for the addressed channel
  always_comb begin
    hit     = '0;
    sel_dat = DEFAULT_READ_VALUE;
    sel_ack = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_idx == SLOT_OFFSET + i) begin
        hit[i]  = 1'b1;
        sel_dat = Slv_DAT_i[DATA_W*i +: DATA_W];
        sel_ack = Slv_ACK_i[i];
      end
    end
  end

  // Per-channel CYC; 8-bit slaves only see writes that hit byte 0
  always_comb begin
    Slv_CYC_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      Slv_CYC_o[i] = hit[i] & WBs_CYC_i & cyc_ok & ~WBs_RST_i &
                     (WBs_RD_i | (WBs_WE_i &
                     (~BYTE0_WR_MASK[i] | WBs_BYTE_STB_i[0])));
    end
  end

  // State register
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, ACK/data steering and watchdog controls
  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    dat      = sel_dat;
    load     = 1'b0;
    inc      = 1'b0;
    fire     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (WBs_CYC_i && WBs_STB_i) begin
          state_nx = S_ACTIVE;
          load     = 1'b1;
        end
      end
      S_ACTIVE: begin
        inc = 1'b1;
        if (!WBs_CYC_i) begin
          state_nx = S_IDLE;
        end else if (sel_ack) begin
          ack      = 1'b1;
          state_nx = S_DONE;
        end else if (expired) begin
          state_nx = S_FORCE;
        end
      end
      S_FORCE: begin
        ack      = 1'b1;
        dat      = DEFAULT_READ_VALUE;
        fire     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        if (!WBs_CYC_i || !WBs_STB_i) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign WBs_ACK_o = ack & ~WBs_RST_i;
  assign WBs_DAT_o = WBs_RST_i ? '0 : dat;
  assign Timeout_o = timeout & ~WBs_RST_i;

  al4s3b_wb_timeout #(
    .APERWIDTH      (APERWIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNTR_WIDTH     (CNTR_WIDTH)
  ) u_timeout (
    .clk     (WBs_CLK_i),
    .rst     (WBs_RST_i),
    .load    (load),
    .inc     (inc),
    .fire    (fire),
    .adr     (WBs_ADR_i),
    .expired (expired),
    .timeout (timeout),
    .err_cnt (Err_Cnt_o),
    .err_adr (Err_Adr_o)
  );

endmodule

// File: tb/tb_al4s3b_wb_slot_decoder.sv
// Directed testbench for the Wishbone slot decoder.
// Channel 2 is configured as an 8-bit write slave.
module tb_al4s3b_wb_slot_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic [16:0]  adr;
  logic         cyc;
  logic [3:0]   bstb;
  logic         we;
  logic         rd;
  logic         stb;
  logic [31:0]  dat;
  logic         ack;
  logic [3:0]   slv_cyc;
  logic [127:0] slv_dat;
  logic [3:0]   slv_ack;
  logic         tmo;
  logic [15:0]  err_cnt;
  logic [16:0]  err_adr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BAD = 32'hBAD_FAB_AC;

  always #5 clk = ~clk;

  al4s3b_wb_slot_decoder #(
    .NUM_SLOTS     (4),
    .BYTE0_WR_MASK (16'h0004)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_BYTE_STB_i (bstb),
    .WBs_WE_i       (we),
    .WBs_RD_i       (rd),
    .WBs_STB_i      (stb),
    .WBs_DAT_o      (dat),
    .WBs_ACK_o      (ack),
    .Slv_CYC_o      (slv_cyc),
    .Slv_DAT_i      (slv_dat),
    .Slv_ACK_i      (slv_ack),
    .Timeout_o      (tmo),
    .Err_Cnt_o      (err_cnt),
    .Err_Adr_o      (err_adr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = clock edges after the edge that starts the transfer
  task automatic xfer(input  logic [16:0] a,
                      input  logic        w,
                      input  logic [3:0]  bs,
                      input  int          ack_n,
                      input  logic [3:0]  ack_m,
                      output int          lat,
                      output logic [31:0] d,
                      output logic        to,
                      output logic [3:0]  cs);
    adr  = a;
    we   = w;
    rd   = ~w;
    bstb = bs;
    cyc  = 1'b1;
    stb  = 1'b1;
    lat  = -1;
    d    = '0;
    to   = 1'b0;
    #1;
    cs = slv_cyc;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == ack_n) begin
        slv_ack = ack_m;
        #1;
      end
      cs = cs | slv_cyc;
      if (ack) begin
        lat = n - 1;
        d   = dat;
        to  = tmo;
        break;
      end
    end
    if (lat >= 0) begin
      step();
      chk("ack_single", 64'(ack), 64'd0);
    end
    cyc     = 1'b0;
    stb     = 1'b0;
    rd      = 1'b0;
    we      = 1'b0;
    slv_ack = '0;
    step();
  endtask

  int          lat;
  logic [31:0] d;
  logic        to;
  logic [3:0]  cs;
  logic        seen;

  initial begin
    rst     = 1'b1;
    adr     = '0;
    cyc     = 1'b0;
    bstb    = 4'hF;
    we      = 1'b0;
    rd      = 1'b0;
    stb     = 1'b0;
    slv_ack = '0;
    slv_dat = {32'h3333_3333, 32'h2222_2222,
               32'h1111_1111, 32'hC0C0_0000};
    step();
    step();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_tmo", 64'(tmo), 64'd0);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    chk("rst_adr", 64'(err_adr), 64'd0);
    chk("rst_cyc", 64'(slv_cyc), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    rst = 1'b0;
    step();

    // Channel 1 read, slave answers
    xfer(17'h01004, 1'b0, 4'hF, 2, 4'b0010, lat, d, to, cs);
    chk("t1_lat", 64'(lat), 64'd1);
    chk("t1_dat", 64'(d), 64'h1111_1111);
    chk("t1_tmo", 64'(to), 64'd0);
    chk("t1_cyc", 64'(cs), 64'b0010);
    chk("t1_cnt", 64'(err_cnt), 64'd0);

    // Unmapped slot times out
    xfer(17'h1F000, 1'b0, 4'hF, 0, 4'b0, lat, d, to, cs);
    chk("t2_lat", 64'(lat), 64'd7);
    chk("t2_dat", 64'(d), 64'(BAD));
    chk("t2_tmo", 64'(to), 64'd1);
    chk("t2_cyc", 64'(cs), 64'd0);
    chk("t2_adr", 64'(err_adr), 64'h1F000);
    chk("t2_cnt", 64'(err_cnt), 64'd1);

    // 8-bit slave: write without byte 0 is suppressed
    xfer(17'h02000, 1'b1, 4'b0010, 0, 4'b0, lat, d, to, cs);
    chk("t3a_cyc", 64'(cs), 64'd0);
    chk("t3a_lat", 64'(lat), 64'd7);
    chk("t3a_tmo", 64'(to), 64'd1);
    chk("t3a_cnt", 64'(err_cnt), 64'd2);

    xfer(17'h02000, 1'b1, 4'b0001, 0, 4'b0, lat, d, to, cs);
    chk("t3b_cyc", 64'(cs), 64'b0100);
    chk("t3b_cnt", 64'(err_cnt), 64'd3);

    // ACK from another channel is ignored
    xfer(17'h01000, 1'b0, 4'hF, 2, 4'b0001, lat, d, to, cs);
    chk("nsel_lat", 64'(lat), 64'd7);
    chk("nsel_dat", 64'(d), 64'(BAD));
    chk("nsel_cnt", 64'(err_cnt), 64'd4);
    chk("nsel_adr", 64'(err_adr), 64'h01000);

    // Slave ACK on the timeout cycle wins
    xfer(17'h03010, 1'b0, 4'hF, 7, 4'b1000, lat, d, to, cs);
    chk("t4_lat", 64'(lat), 64'd6);
    chk("t4_dat", 64'(d), 64'h3333_3333);
    chk("t4_tmo", 64'(to), 64'd0);
    chk("t4_cnt", 64'(err_cnt), 64'd4);

    // CYC dropped mid-transfer: no ACK, no count
    adr = 17'h1F000;
    rd  = 1'b1;
    cyc = 1'b1;
    stb = 1'b1;
    step();
    step();
    step();
    cyc  = 1'b0;
    stb  = 1'b0;
    rd   = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen = seen | ack | tmo;
    end
    chk("drop_ack", 64'(seen), 64'd0);
    chk("drop_cnt", 64'(err_cnt), 64'd4);

    // Saturation of the error count
    force dut.u_timeout.err_cnt = 16'hFFFE;
    #1;
    release dut.u_timeout.err_cnt;
    xfer(17'h1D000, 1'b0, 4'hF, 0, 4'b0, lat, d, to, cs);
    chk("t5_cnt1", 64'(err_cnt), 64'hFFFF);
    xfer(17'h1E000, 1'b0, 4'hF, 0, 4'b0, lat, d, to, cs);
    chk("t5_tmo", 64'(to), 64'd1);
    chk("t5_cnt2", 64'(err_cnt), 64'hFFFF);
    chk("t5_adr", 64'(err_adr), 64'h1E000);

    // Reset during a pending read
    adr = 17'h01000;
    rd  = 1'b1;
    cyc = 1'b1;
    stb = 1'b1;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6_ack", 64'(ack), 64'd0);
    chk("t6_tmo", 64'(tmo), 64'd0);
    chk("t6_cnt", 64'(err_cnt), 64'd0);
    chk("t6_adr", 64'(err_adr), 64'd0);
    chk("t6_cyc", 64'(slv_cyc), 64'd0);
    chk("t6_dat", 64'(dat), 64'd0);
    rst = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    rd  = 1'b0;
    step();
    xfer(17'h00008, 1'b0, 4'hF, 3, 4'b0001, lat, d, to, cs);
    chk("t6r_lat", 64'(lat), 64'd2);
    chk("t6r_dat", 64'(d), 64'hC0C0_0000);
    chk("t6r_cnt", 64'(err_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
